// File: rtl/xor_rotate_cipher.sv
// Stream cipher stage: XORs each data word with a programmable key rotated left per beat,
// buffering ciphertext in an output FIFO. Define XOR_ROTATE_CIPHER_ROLLING_KEY_EN for rolling-key mode.
module xor_rotate_cipher #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ROT_W = $clog2(WIDTH),
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in_p,
    input  logic [ROT_W-1:0] key_rotation_p,
    input  logic             prog_p,
    input  logic             data_ready_in_p,
    output logic             ready_p,
    output logic [WIDTH-1:0] data_out_c,
    output logic             data_ready_out_c,
    input  logic             capture_c,
    output logic             no_key_err
);

    localparam int unsigned RotAmtW = $clog2(WIDTH);
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

`ifdef XOR_ROTATE_CIPHER_ROLLING_KEY_EN
    localparam bit RollEn = 1'b1;
`else
    localparam bit RollEn = 1'b0;
`endif

    typedef enum logic [0:0] {KeyEmpty, KeyLoaded} key_state_e;

    key_state_e       key_state_q, key_state_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic             no_key_err_q, no_key_err_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             full, empty;
    logic             in_xfer, push, pop;
    logic [RotAmtW-1:0] rot_amt;
    logic [WIDTH-1:0] rk;
    logic [WIDTH-1:0] cipher;

    // Rotation amount is taken modulo WIDTH, i.e. its low RotAmtW bits.
    if (ROT_W >= RotAmtW) begin : g_rot_trunc
        assign rot_amt = key_rotation_p[RotAmtW-1:0];
    end else begin : g_rot_ext
        assign rot_amt = {{(RotAmtW - ROT_W){1'b0}}, key_rotation_p};
    end

    // Logarithmic barrel rotator: stage s rotates by 2**s when rot_amt[s] is set.
    always_comb begin
        rk = key_q;
        for (int s = 0; s < RotAmtW; s++) begin
            if (rot_amt[s]) begin
                rk = (rk << (1 << s)) | (rk >> (WIDTH - (1 << s)));
            end
        end
    end

    assign cipher = data_in_p ^ rk;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign ready_p = !full && !reset;
    assign in_xfer = data_ready_in_p && ready_p;
    assign push    = in_xfer && !prog_p && (key_state_q == KeyLoaded);
    assign pop     = !empty && capture_c;

    assign data_ready_out_c = !empty;
    assign data_out_c       = empty ? '0 : mem_q[rd_ptr_q];
    assign no_key_err       = no_key_err_q;

    always_comb begin
        key_state_d  = key_state_q;
        key_d        = key_q;
        no_key_err_d = no_key_err_q;
        if (in_xfer) begin
            if (prog_p) begin
                key_state_d  = KeyLoaded;
                key_d        = data_in_p;
                no_key_err_d = 1'b0;
            end else if (key_state_q == KeyEmpty) begin
                no_key_err_d = 1'b1;
            end else if (RollEn) begin
                key_d = rk;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_state_q  <= KeyEmpty;
            key_q        <= '0;
            no_key_err_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            key_state_q  <= key_state_d;
            key_q        <= key_d;
            no_key_err_q <= no_key_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the output is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cipher;
        end
    end

endmodule

// File: tb/tb_xor_rotate_cipher.sv
// Self-checking bench for xor_rotate_cipher: vector table, scoreboard queue, hand sequences
// for backpressure, rolling key and asynchronous reset.
module tb_xor_rotate_cipher;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset;
    logic [31:0] data_in_p;
    logic [4:0]  key_rotation_p;
    logic        prog_p;
    logic        data_ready_in_p;
    logic        ready_p;
    logic [31:0] data_out_c;
    logic        data_ready_out_c;
    logic        capture_c;
    logic        no_key_err;

    xor_rotate_cipher #(
        .WIDTH(32),
        .ROT_W(5),
        .DEPTH(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in_p       (data_in_p),
        .key_rotation_p  (key_rotation_p),
        .prog_p          (prog_p),
        .data_ready_in_p (data_ready_in_p),
        .ready_p         (ready_p),
        .data_out_c      (data_out_c),
        .data_ready_out_c(data_ready_out_c),
        .capture_c       (capture_c),
        .no_key_err      (no_key_err)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic        prog;
        logic [31:0] data;
        logic [4:0]  rot;
        logic        has_out;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;

    logic [31:0] key_m = '0;
    logic        loaded_m = 1'b0;
    logic        err_m = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic void add(input logic p, input logic [31:0] d, input logic [4:0] r,
                                input logic h, input logic [31:0] e, input logic er);
        vec_t v;
        v.prog = p; v.data = d; v.rot = r; v.has_out = h; v.exp = e; v.exp_err = er;
        vecs.push_back(v);
    endfunction

    // Bit-at-a-time rotation, independent of the DUT's shifter structure.
    function automatic logic [31:0] rotl(input logic [31:0] k, input logic [4:0] r);
        logic [31:0] t = k;
        for (int i = 0; i < int'(r); i++) t = {t[30:0], t[31]};
        return t;
    endfunction

    function automatic void model_apply(input logic p, input logic [31:0] d, input logic [4:0] r);
        logic [31:0] rk;
        if (p) begin
            key_m = d; loaded_m = 1'b1; err_m = 1'b0;
        end else if (!loaded_m) begin
            err_m = 1'b1;
        end else begin
            rk = rotl(key_m, r);
            exp_q.push_back(d ^ rk);
`ifdef XOR_ROTATE_CIPHER_ROLLING_KEY_EN
            key_m = rk;
`endif
        end
    endfunction

    // Output scoreboard: a transfer is due at the next rising edge when valid && capture here.
    always @(negedge clk) begin
        if (!reset && data_ready_out_c && capture_c) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", data_out_c, 32'hxxxx_xxxx);
            end else begin
                check("fifo_out", data_out_c, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic p, input logic [31:0] d, input logic [4:0] r,
                        output logic acc);
        prog_p = p; data_in_p = d; key_rotation_p = r; data_ready_in_p = 1'b1; acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (ready_p) acc = 1'b1;
            @(posedge clk); #1;
            if (!acc) capture_c = 1'b1;
        end
        data_ready_in_p = 1'b0; prog_p = 1'b0;
        check("beat_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    logic acc;

    initial begin
        reset = 1'b1; data_in_p = '0; key_rotation_p = '0; prog_p = 1'b0;
        data_ready_in_p = 1'b0; capture_c = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_p}, 32'd0);
        check("rst_valid", {31'd0, data_ready_out_c}, 32'd0);
        check("rst_data", data_out_c, 32'd0);
        check("rst_err", {31'd0, no_key_err}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_release", {31'd0, ready_p}, 32'd1);
        @(posedge clk); #1;

        // Vector table
        add(0, 32'hAAAA_AAAA, 5'd0, 0, 32'h0, 1);
        add(1, 32'h0000_0001, 5'd0, 0, 32'h0, 0);
        add(0, 32'h0000_0000, 5'd0, 1, 32'h0000_0001, 0);
        add(1, 32'h0000_00FF, 5'd0, 0, 32'h0, 0);
        add(0, 32'h1234_5678, 5'd4, 1, 32'h1234_5988, 0);
        add(1, 32'h8000_0001, 5'd0, 0, 32'h0, 0);
        add(0, 32'h0000_0000, 5'd1, 1, 32'h0000_0003, 0);
`ifdef XOR_ROTATE_CIPHER_ROLLING_KEY_EN
        add(0, 32'hFFFF_FFFF, 5'd0, 1, 32'hFFFF_FFFC, 0);
`else
        add(0, 32'hFFFF_FFFF, 5'd0, 1, 32'h7FFF_FFFE, 0);
`endif
        add(1, 32'h0000_00FF, 5'd0, 0, 32'h0, 0);
        add(0, 32'h0000_0000, 5'd4, 1, 32'h0000_0FF0, 0);
`ifdef XOR_ROTATE_CIPHER_ROLLING_KEY_EN
        add(0, 32'h0000_0000, 5'd4, 1, 32'h0000_FF00, 0);
`else
        add(0, 32'h0000_0000, 5'd4, 1, 32'h0000_0FF0, 0);
`endif
        add(1, 32'h0000_0001, 5'd0, 0, 32'h0, 0);
        add(0, 32'h0000_0000, 5'd31, 1, 32'h8000_0000, 0);
`ifdef XOR_ROTATE_CIPHER_ROLLING_KEY_EN
        add(0, 32'h0F0F_0F0F, 5'd16, 1, 32'h0F0F_8F0F, 0);
`else
        add(0, 32'h0F0F_0F0F, 5'd16, 1, 32'h0F0E_0F0F, 0);
`endif

        capture_c = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].prog, vecs[i].data, vecs[i].rot, acc);
            if (vecs[i].has_out) exp_q.push_back(vecs[i].exp);
            check("vec_no_key_err", {31'd0, no_key_err}, {31'd0, vecs[i].exp_err});
        end
        drain();

        // Basic encrypt: output valid for exactly one cycle
        send(1, 32'h0000_00FF, 5'd0, acc); model_apply(1, 32'h0000_00FF, 5'd0);
        send(0, 32'h1234_5678, 5'd4, acc); model_apply(0, 32'h1234_5678, 5'd4);
        check("basic_valid", {31'd0, data_ready_out_c}, 32'd1);
        check("basic_data", data_out_c, 32'h1234_5988);
        @(posedge clk); #1;
        check("basic_valid_gone", {31'd0, data_ready_out_c}, 32'd0);

        // Backpressure: fill to DEPTH with capture held low
        capture_c = 1'b0;
        send(1, 32'h0, 5'd0, acc); model_apply(1, 32'h0, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            send(0, 32'(i), 5'd0, acc); model_apply(0, 32'(i), 5'd0);
        end
        check("full_ready_low", {31'd0, ready_p}, 32'd0);
        prog_p = 1'b0; data_in_p = 32'd5; key_rotation_p = '0; data_ready_in_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fifth_blocked", {31'd0, ready_p}, 32'd0);
        end
        @(posedge clk); #1;
        data_ready_in_p = 1'b0;
        capture_c = 1'b1;
        @(negedge clk);
        check("ready_before_pop", {31'd0, ready_p}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_pop", {31'd0, ready_p}, 32'd1);
        drain();
        check("bp_empty", {31'd0, data_ready_out_c}, 32'd0);

        // Random traffic against the model, with intermittent capture
        send(1, $urandom, 5'd0, acc); model_apply(1, data_in_p, 5'd0);
        for (int i = 0; i < 40; i++) begin
            logic        p;
            logic [31:0] d;
            logic [4:0]  r;
            p = ($urandom_range(0, 5) == 0);
            d = $urandom;
            r = 5'($urandom_range(0, 31));
            capture_c = ($urandom_range(0, 3) != 0);
            send(p, d, r, acc);
            model_apply(p, d, r);
        end
        capture_c = 1'b1;
        drain();

        // Asynchronous reset with 3 entries buffered and the clock stopped
        capture_c = 1'b0;
        send(1, 32'h0000_000F, 5'd0, acc); model_apply(1, 32'h0000_000F, 5'd0);
        for (int i = 1; i <= 3; i++) begin
            send(0, 32'(i), 5'd0, acc); model_apply(0, 32'(i), 5'd0);
        end
        check("pre_reset_valid", {31'd0, data_ready_out_c}, 32'd1);
        check("pre_reset_head", data_out_c, 32'h0000_000E);
        clk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, data_ready_out_c}, 32'd0);
        check("async_data", data_out_c, 32'd0);
        check("async_ready", {31'd0, ready_p}, 32'd0);
        exp_q.delete();
        key_m = '0; loaded_m = 1'b0; err_m = 1'b0;
        #5 reset = 1'b0;
        #1 clk_en = 1'b1;
        @(posedge clk); #1;
        capture_c = 1'b1;
        send(0, 32'h5555_5555, 5'd3, acc); model_apply(0, 32'h5555_5555, 5'd3);
        check("post_reset_err", {31'd0, no_key_err}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_no_out", {31'd0, data_ready_out_c}, 32'd0);
        check("final_queue", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xor_rotate_cipher.md
# xor_rotate_cipher

Parametrised stream cipher stage between the Parallelizer and the Collector. It holds a programmable key and XORs each data word with the key rotated left by a per-beat amount. Results are buffered in an output FIFO so the Parallelizer is not stalled by a slow Collector. Width and buffer depth are generic, and an optional rolling-key mode is available.

## Interface
- `WIDTH`, default 32: data/key width; power of two, at least 8.
- `ROT_W`, default `$clog2(WIDTH)`: width of the rotation amount.
- `DEPTH`, default 4: output FIFO entries; power of two, at least 2.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in_p`  in  WIDTH  key word (program beat) or plaintext word (data beat).
- `key_rotation_p`  in  ROT_W  left-rotation amount for this data beat.
- `prog_p`  in  1  qualifies the beat as a key load.
- `data_ready_in_p`  in  1  input valid.
- `ready_p`  out  1  input ready.
- `data_out_c`  out  WIDTH  ciphertext at the FIFO head.
- `data_ready_out_c`  out  1  output valid (FIFO not empty).
- `capture_c`  in  1  output accept.
- `no_key_err`  out  1  sticky flag: a data beat arrived before any key was loaded.

## Operation
- **Input transfer:** occurs on a rising edge where `data_ready_in_p` and `ready_p` are both 1.
- **Output transfer:** occurs on a rising edge where `data_ready_out_c` and `capture_c` are both 1.
- **Key state:**
  - `KEY_EMPTY` moves to `KEY_LOADED` on a program beat.
  - Only `reset` returns the block to `KEY_EMPTY`.
- **Program beat** (`prog_p`=1):
  - `key <= data_in_p`; `no_key_err <= 0`.
  - Nothing is pushed to the FIFO, and `key_rotation_p` is ignored.
- **Data beat in `KEY_LOADED`:**
  - Compute `rk = rotl(key, key_rotation_p)`, modulo WIDTH.
  - Push `data_in_p ^ rk` to the FIFO.
  - A rotation of 0 uses the key unchanged.
- **Data beat in `KEY_EMPTY`:** the beat is consumed and dropped, no push occurs, and `no_key_err <= 1`.
- **Ready rule:** `ready_p = !full && !reset`, decoded from the registered occupancy count. Program beats also require `!full`.
- **Re-key mid-stream:** takes effect for data beats after the program beat. Entries already in the FIFO are unaffected.
- **FIFO:**
  - Order is preserved.
  - Read/write pointers wrap modulo DEPTH; the count spans 0..DEPTH.
  - `data_out_c` shows the head entry, and holds 0 when the FIFO is empty.
- **Simultaneous push and pop** (FIFO not empty, not full): both happen and the count is unchanged.
- **Full FIFO with `capture_c`=1:** the pop happens; `ready_p` rises in the following cycle (no same-cycle pass-through).

## Timing
- **Reset values, asserted asynchronously:**
  - `ready_p`=0, `data_ready_out_c`=0, `data_out_c`=0, `no_key_err`=0.
  - Key = 0, state `KEY_EMPTY`, pointers and count = 0.
- **After reset release:** `ready_p`=1 combinationally.
- **Latency:** a data beat accepted at edge N gives `data_ready_out_c`=1 from edge N onward, provided the FIFO was empty before edge N.
- **Throughput:** one beat per cycle in each direction.
- **Reset mid-operation:** all buffered words are discarded and the key is lost; a new program beat is required.
- **Program and data in the same beat:** impossible, since `prog_p` selects one or the other.
- **Back-to-back beats:** a program beat at edge N followed by a data beat at N+1 uses the new key.

## Configuration
- Macro: `XOR_ROTATE_CIPHER_ROLLING_KEY_EN`.
- **Defined:** after each accepted data beat in `KEY_LOADED`, `key <= rk`. Successive rotations therefore accumulate, and the Collector side must track the same key sequence.
- **Undefined:** the key changes only on program beats.

## Test plan
- **Basic encrypt** (WIDTH=32):
  - Stimulus: program 0x000000FF, then data 0x12345678 with rot 4, `capture_c`=1.
  - Required: `data_out_c`=0x12345988, valid exactly one cycle.
- **Rotation wrap:**
  - Stimulus: program 0x80000001, then data 0x00000000 with rot 1.
  - Required: output 0x00000003. Then rot 0 with data 0xFFFFFFFF gives 0x7FFFFFFE.
- **No key:**
  - Stimulus: data beat 0xAAAAAAAA straight after reset.
  - Required: no output, `no_key_err`=1.
  - Follow-up: program 0x1 clears `no_key_err`, and data 0 with rot 0 outputs 0x00000001.
- **Backpressure** (DEPTH=4, `capture_c`=0):
  - Stimulus: push data 1..4 with key 0, rot 0.
  - Required: `ready_p`=0 after the 4th push and a 5th beat is not accepted.
  - Follow-up: `capture_c`=1 pops 1,2,3,4 in order; `ready_p` returns one cycle after the first pop.
- **Rolling key:**
  - Stimulus: key 0x000000FF, two data-0 beats with rot 4.
  - Required with the macro: outputs 0x00000FF0, 0x0000FF00.
  - Required without the macro: 0x00000FF0, 0x00000FF0.
- **Async reset** with 3 entries buffered and the clock stopped:
  - Required: `data_ready_out_c` and `data_out_c` go to 0 immediately.
  - Follow-up: a data beat after release sets `no_key_err`.
